// File: rtl/br_lite_local_ni.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : br_lite_local_ni                                                |
// | Brief    : PE-side network interface for a BrLite router LOCAL port.       |
// |            TX FIFO + req/ack injector, RX FIFO toward the PE.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module br_lite_local_ni #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] pe_tx_flit_i,
  input  logic              pe_tx_valid_i,
  output logic              pe_tx_ready_o,
  output logic [DATA_W-1:0] pe_rx_flit_o,
  output logic              pe_rx_valid_o,
  input  logic              pe_rx_ready_i,
  output logic [DATA_W-1:0] noc_flit_o,
  output logic              noc_req_o,
  input  logic              noc_ack_i,
  input  logic              noc_busy_i,
  input  logic [DATA_W-1:0] noc_flit_i,
  input  logic              noc_req_i,
  output logic              noc_ack_o,
  output logic [31:0]       tx_cnt_o,
  output logic [31:0]       rx_cnt_o
);

  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int RXAW = $clog2(RX_DEPTH);
  localparam logic [TXAW:0] C_TX_FULL = (TXAW+1)'(TX_DEPTH);
  localparam logic [RXAW:0] C_RX_FULL = (RXAW+1)'(RX_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [DATA_W-1:0] r_tx_mem [TX_DEPTH];
  logic [TXAW-1:0]   r_tx_wptr;
  logic [TXAW-1:0]   r_tx_rptr;
  logic [TXAW:0]     r_tx_count;
  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_noc_flit;
  logic              r_noc_req;
  logic [31:0]       r_tx_cnt;

  logic [DATA_W-1:0] r_rx_mem [RX_DEPTH];
  logic [RXAW-1:0]   r_rx_wptr;
  logic [RXAW-1:0]   r_rx_rptr;
  logic [RXAW:0]     r_rx_count;
  logic [31:0]       r_rx_cnt;

  logic w_tx_push;
  logic w_tx_pop;
  logic w_rx_push;
  logic w_rx_pop;

  assign pe_tx_ready_o = (r_tx_count != C_TX_FULL);
  assign w_tx_push     = pe_tx_valid_i && pe_tx_ready_o;
  assign w_tx_pop      = (r_state == S_REQ) && noc_ack_i;

  // Ack is withheld on a full FIFO even if the PE pops this cycle.
  assign noc_ack_o     = noc_req_i && (r_rx_count != C_RX_FULL);
  assign w_rx_push     = noc_req_i && noc_ack_o;
  assign pe_rx_valid_o = (r_rx_count != '0);
  assign w_rx_pop      = pe_rx_valid_o && pe_rx_ready_i;
  assign pe_rx_flit_o  = r_rx_mem[r_rx_rptr];

  assign noc_flit_o = r_noc_flit;
  assign noc_req_o  = r_noc_req;
  assign tx_cnt_o   = r_tx_cnt;
  assign rx_cnt_o   = r_rx_cnt;

  always_ff @(posedge clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= pe_tx_flit_i;
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= noc_flit_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_wptr  <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // Injector: the GAP state forces one req-low cycle between flits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_noc_req  <= 1'b0;
      r_noc_flit <= '0;
      r_tx_rptr  <= '0;
      r_tx_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((r_tx_count != '0) && !noc_busy_i) begin
            r_state    <= S_REQ;
            r_noc_req  <= 1'b1;
            r_noc_flit <= r_tx_mem[r_tx_rptr];
          end
        end
        S_REQ: begin
          if (noc_ack_i) begin
            r_state   <= S_GAP;
            r_noc_req <= 1'b0;
            r_tx_rptr <= r_tx_rptr + 1'b1;
            r_tx_cnt  <= r_tx_cnt + 32'd1;
          end
        end
        S_GAP:   r_state <= S_IDLE;
        default: begin
          r_state   <= S_IDLE;
          r_noc_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
      r_rx_cnt   <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_wptr <= r_rx_wptr + 1'b1;
        r_rx_cnt  <= r_rx_cnt + 32'd1;
      end
      if (w_rx_pop) r_rx_rptr <= r_rx_rptr + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_br_lite_local_ni.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_br_lite_local_ni                                             |
// | Brief    : Self-checking bench: queue-based reference plus directed cases. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_br_lite_local_ni;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] pe_tx_flit_i;
  logic        pe_tx_valid_i;
  logic        pe_tx_ready_o;
  logic [31:0] pe_rx_flit_o;
  logic        pe_rx_valid_o;
  logic        pe_rx_ready_i;
  logic [31:0] noc_flit_o;
  logic        noc_req_o;
  logic        noc_ack_i;
  logic        noc_busy_i;
  logic [31:0] noc_flit_i;
  logic        noc_req_i;
  logic        noc_ack_o;
  logic [31:0] tx_cnt_o;
  logic [31:0] rx_cnt_o;

  br_lite_local_ni #(.TX_DEPTH(4), .RX_DEPTH(4), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .pe_tx_flit_i(pe_tx_flit_i), .pe_tx_valid_i(pe_tx_valid_i), .pe_tx_ready_o(pe_tx_ready_o),
    .pe_rx_flit_o(pe_rx_flit_o), .pe_rx_valid_o(pe_rx_valid_o), .pe_rx_ready_i(pe_rx_ready_i),
    .noc_flit_o(noc_flit_o), .noc_req_o(noc_req_o), .noc_ack_i(noc_ack_i),
    .noc_busy_i(noc_busy_i), .noc_flit_i(noc_flit_i), .noc_req_i(noc_req_i),
    .noc_ack_o(noc_ack_o), .tx_cnt_o(tx_cnt_o), .rx_cnt_o(rx_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: queues of flits plus the injector's request/gap timing.
  logic [31:0] m_txq[$];
  logic [31:0] m_rxq[$];
  bit          m_req, m_gap;
  logic [31:0] m_flit;
  logic [31:0] m_txc, m_rxc;
  int          osz, rsz;
  bit          tpush, rack;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_txq.delete(); m_rxq.delete();
      m_req = 0; m_gap = 0; m_flit = '0; m_txc = '0; m_rxc = '0;
    end else begin
      osz   = m_txq.size();
      tpush = pe_tx_valid_i && (osz < 4);
      if (m_req) begin
        if (noc_ack_i) begin
          void'(m_txq.pop_front());
          m_req = 0; m_gap = 1; m_txc = m_txc + 1;
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (osz > 0 && !noc_busy_i) begin
        m_req = 1; m_flit = m_txq[0];
      end
      if (tpush) m_txq.push_back(pe_tx_flit_i);
      rsz  = m_rxq.size();
      rack = noc_req_i && (rsz < 4);
      if (rsz > 0 && pe_rx_ready_i) void'(m_rxq.pop_front());
      if (rack) begin
        m_rxq.push_back(noc_flit_i);
        m_rxc = m_rxc + 1;
      end
    end
  end

  always @(negedge clk_i) begin
    chk("cyc_req",   noc_req_o,     m_req);
    chk("cyc_flit",  noc_flit_o,    m_flit);
    chk("cyc_txrdy", pe_tx_ready_o, m_txq.size() < 4);
    chk("cyc_rxval", pe_rx_valid_o, m_rxq.size() > 0);
    if (m_rxq.size() > 0) chk("cyc_rxflit", pe_rx_flit_o, m_rxq[0]);
    chk("cyc_ack",   noc_ack_o,     noc_req_i && (m_rxq.size() < 4));
    chk("cyc_txcnt", tx_cnt_o,      m_txc);
    chk("cyc_rxcnt", rx_cnt_o,      m_rxc);
  end

  // Observed handshakes, for order and spacing checks.
  int          cyc = 0;
  int          inj_t[$];
  logic [31:0] inj_f[$];
  logic [31:0] rx_got[$];
  always @(posedge clk_i) begin
    cyc++;
    if (rst_ni && noc_req_o && noc_ack_i) begin
      inj_t.push_back(cyc);
      inj_f.push_back(noc_flit_o);
    end
    if (rst_ni && pe_rx_valid_o && pe_rx_ready_i) rx_got.push_back(pe_rx_flit_o);
  end

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic push_tx(input logic [31:0] f);
    pe_tx_valid_i = 1'b1;
    pe_tx_flit_i  = f;
    step();
    pe_tx_valid_i = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!noc_req_o && n < budget) begin
      step();
      n++;
    end
    chk("wait_req_timeout", noc_req_o, 1'b1);
  endtask

  logic [31:0] rxf [5];
  int          sent;
  bit          a;
  int          n;

  initial begin
    rxf = '{32'h41, 32'h42, 32'h43, 32'h44, 32'h45};
    rst_ni = 1'b0; pe_tx_flit_i = '0; pe_tx_valid_i = 0; pe_rx_ready_i = 0;
    noc_ack_i = 1'b1; noc_busy_i = 0; noc_flit_i = '0; noc_req_i = 0;
    repeat (3) step();
    chk("rst_req",   noc_req_o,     1'b0);
    chk("rst_flit",  noc_flit_o,    32'h0);
    chk("rst_txrdy", pe_tx_ready_o, 1'b1);
    chk("rst_rxval", pe_rx_valid_o, 1'b0);
    chk("rst_ack",   noc_ack_o,     1'b0);
    rst_ni = 1'b1;
    step();

    // 1: single injection, ack tied high
    push_tx(32'h11);
    chk("t1_req_e0", noc_req_o, 1'b0);
    step();
    chk("t1_req_e1",  noc_req_o,  1'b1);
    chk("t1_flit_e1", noc_flit_o, 32'h11);
    step();
    chk("t1_req_drop", noc_req_o, 1'b0);
    chk("t1_txcnt",    tx_cnt_o,  32'd1);

    // 2: busy holds off injection, then in-order with >=3 cycle spacing
    inj_t.delete(); inj_f.delete();
    noc_busy_i = 1'b1;
    push_tx(32'h21); push_tx(32'h22); push_tx(32'h23);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_busy_req", noc_req_o, 1'b0);
    end
    noc_busy_i = 1'b0;
    n = 0;
    while (inj_t.size() < 3 && n < 40) begin step(); n++; end
    chk("t2_count", inj_t.size(), 3);
    if (inj_t.size() == 3) begin
      chk("t2_f0", inj_f[0], 32'h21);
      chk("t2_f1", inj_f[1], 32'h22);
      chk("t2_f2", inj_f[2], 32'h23);
      chk("t2_gap01", (inj_t[1] - inj_t[0]) >= 3, 1'b1);
      chk("t2_gap12", (inj_t[2] - inj_t[1]) >= 3, 1'b1);
    end
    step(); step();
    chk("t2_txcnt", tx_cnt_o, 32'd4);

    // 3: request held stable while ack is low
    noc_ack_i = 1'b0;
    push_tx(32'h33);
    wait_req(10);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_req_hold",  noc_req_o,  1'b1);
      chk("t3_flit_hold", noc_flit_o, 32'h33);
      chk("t3_cnt_hold",  tx_cnt_o,   32'd4);
    end
    noc_ack_i = 1'b1;
    step();
    chk("t3_req_drop", noc_req_o, 1'b0);
    chk("t3_txcnt",    tx_cnt_o,  32'd5);

    // 4: RX fills to 4, fifth request stalls, then drains in order
    rx_got.delete();
    sent = 0;
    for (int i = 0; i < 8; i++) begin
      noc_req_i  = (sent < 5);
      noc_flit_i = (sent < 5) ? rxf[sent] : 32'h0;
      #1;
      a = noc_ack_o;
      step();
      if (a) sent++;
    end
    chk("t4_sent4",  sent,      4);
    chk("t4_ack0",   noc_ack_o, 1'b0);
    chk("t4_rxcnt4", rx_cnt_o,  32'd4);
    pe_rx_ready_i = 1'b1;
    n = 0;
    while (rx_got.size() < 5 && n < 30) begin
      noc_req_i  = (sent < 5);
      noc_flit_i = (sent < 5) ? rxf[sent] : 32'h0;
      #1;
      a = noc_ack_o && noc_req_i;
      step();
      if (a) sent++;
      n++;
    end
    noc_req_i = 1'b0;
    chk("t4_got5", rx_got.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < rx_got.size()) chk("t4_order", rx_got[i], rxf[i]);
    chk("t4_rxcnt5", rx_cnt_o, 32'd5);

    // 5: TX full drops ready; one injection reopens it
    noc_busy_i = 1'b1;
    push_tx(32'h51); push_tx(32'h52); push_tx(32'h53); push_tx(32'h54);
    chk("t5_full", pe_tx_ready_o, 1'b0);
    push_tx(32'h55);
    noc_busy_i = 1'b0;
    wait_req(10);
    chk("t5_head", noc_flit_o, 32'h51);
    step();
    chk("t5_ready_back", pe_tx_ready_o, 1'b1);
    repeat (12) step();
    chk("t5_txcnt", tx_cnt_o, 32'd9);

    // 6: reset while requesting with two flits queued
    noc_ack_i = 1'b0; noc_busy_i = 1'b1;
    push_tx(32'h61); push_tx(32'h62); push_tx(32'h63);
    noc_busy_i = 1'b0;
    wait_req(10);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_req_async", noc_req_o,     1'b0);
    chk("t6_txcnt0",    tx_cnt_o,      32'd0);
    chk("t6_ready",     pe_tx_ready_o, 1'b1);
    step(); step();
    rst_ni = 1'b1; noc_ack_i = 1'b1;
    step();
    chk("t6_req",   noc_req_o,     1'b0);
    chk("t6_rxval", pe_rx_valid_o, 1'b0);
    chk("t6_rxcnt", rx_cnt_o,      32'd0);
    chk("t6_txrdy", pe_tx_ready_o, 1'b1);
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
